mem_bus_arb: RTL and testbench

- Shares the single external line-refill bus between the instruction-cache and data-cache refill ports of one core.
- Each cache raises a block-address read request and holds it until it receives a one-cycle data-valid pulse with the full line.
- The arbiter selects one requester with round-robin priority, runs one external line read, and registers the returned line.
- It routes the line back to the owner, and a watchdog recovers from a bus that never answers.

---
 rtl/mem_bus_arb_pkg.sv | 24 ++
 rtl/mem_bus_arb_rr_arb2.sv | 26 ++
 rtl/mem_bus_arb.sv | 143 ++++++++++++++
 tb/tb_mem_bus_arb.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arb_pkg.sv
// Shared encodings and default widths for the line-refill bus arbiter.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package mem_bus_arb_pkg;

   // A 64-byte cache line in a 64-bit address space.
   localparam int ADDR_W      = 64;
   localparam int LINE_BYTES  = 64;
   localparam int LINE_OFF_W  = $clog2(LINE_BYTES);
   localparam int BLK_LEN_DEF = ADDR_W - LINE_OFF_W;
   localparam int LINE_DEF    = LINE_BYTES * 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2
   } state_e;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

endpackage

// File: rtl/mem_bus_arb_rr_arb2.sv
// Two-input round-robin grant: on a tie, the requester that was not served last wins.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is consumed.
// Ports: req_i_i/req_d_i requests, last_i previous owner, gnt_vld_o any request, gnt_o owner.
module rr_arb2
   import mem_bus_arb_pkg::*;
(
   input  logic req_i_i,
   input  logic req_d_i,
   input  logic last_i,
   output logic gnt_vld_o,
   output logic gnt_o
);

   always_comb begin
      gnt_vld_o = req_i_i | req_d_i;
      gnt_o     = OWN_I;
      if (req_i_i && req_d_i) begin
         // Owner encodings are one bit, so "not last" is simply the inverse.
         gnt_o = ~last_i;
      end else if (req_d_i) begin
         gnt_o = OWN_D;
      end
   end

endmodule

// File: rtl/mem_bus_arb.sv
// Shares one external line-refill bus between the imem and dmem refill ports.
// Latency: request to x_rd 1 cycle; x_dv to b_dv 1 cycle; 3 cycles minimum per line.
// Backpressure: requesters hold rd until their dv pulse; watchdog abandons a silent bus.
// Ports: b_*_i imem refill port, b_*_d dmem refill port, x_* external bus,
//        bus_err one-cycle pulse when the watchdog gives up on a read.
module mem_bus_arb
   import mem_bus_arb_pkg::*;
#(
   parameter int BLK_LEN = BLK_LEN_DEF,
   parameter int LINE    = LINE_DEF,
   parameter int TIMEOUT = 1024
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [BLK_LEN-1:0] b_addr_i,
   input  logic               b_rd_i,
   output logic [LINE-1:0]    b_rdata_i,
   output logic               b_dv_i,
   input  logic [BLK_LEN-1:0] b_addr_d,
   input  logic               b_rd_d,
   output logic [LINE-1:0]    b_rdata_d,
   output logic               b_dv_d,
   output logic [BLK_LEN-1:0] x_addr,
   output logic               x_rd,
   input  logic [LINE-1:0]    x_rdata,
   input  logic               x_dv,
   output logic               bus_err
);

   localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

   state_e             state_q, state_d;
   owner_e             owner_q, owner_d;
   owner_e             last_q,  last_d;
   logic [WD_W-1:0]    wd_q,    wd_d;
   logic [LINE-1:0]    line_q,  line_d;
   logic [BLK_LEN-1:0] addr_q,  addr_d;
   logic               x_rd_q,  x_rd_d;
   logic               dvi_q,   dvi_d;
   logic               dvd_q,   dvd_d;
   logic               err_q,   err_d;

   logic gnt_vld;
   logic gnt;

   rr_arb2 u_rr_arb2 (
      .req_i_i   (b_rd_i),
      .req_d_i   (b_rd_d),
      .last_i    (last_q),
      .gnt_vld_o (gnt_vld),
      .gnt_o     (gnt)
   );

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      wd_d    = wd_q;
      line_d  = line_q;
      addr_d  = addr_q;
      x_rd_d  = x_rd_q;
      dvi_d   = 1'b0;
      dvd_d   = 1'b0;
      err_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (gnt_vld) begin
               owner_d = owner_e'(gnt);
               addr_d  = (owner_e'(gnt) == OWN_D) ? b_addr_d : b_addr_i;
               x_rd_d  = 1'b1;
               wd_d    = '0;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            wd_d = wd_q + 1'b1;
            // x_dv is tested first so a reply on the expiry cycle still completes.
            if (x_dv) begin
               line_d  = x_rdata;
               x_rd_d  = 1'b0;
               state_d = S_RESP;
               // The dv register is loaded here so it is visible in S_RESP;
               // an owner that has already let go of rd gets nothing.
               if (owner_q == OWN_D) begin
                  dvd_d = b_rd_d;
               end else begin
                  dvi_d = b_rd_i;
               end
            end else if ((TIMEOUT != 0) && (wd_q == WD_LAST)) begin
               x_rd_d  = 1'b0;
               err_d   = 1'b1;
               last_d  = owner_q;
               state_d = S_IDLE;
            end
         end
         S_RESP: begin
            last_d  = owner_q;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         owner_q <= OWN_I;
         last_q  <= OWN_D;
         wd_q    <= '0;
         line_q  <= '0;
         addr_q  <= '0;
         x_rd_q  <= 1'b0;
         dvi_q   <= 1'b0;
         dvd_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         wd_q    <= wd_d;
         line_q  <= line_d;
         addr_q  <= addr_d;
         x_rd_q  <= x_rd_d;
         dvi_q   <= dvi_d;
         dvd_q   <= dvd_d;
         err_q   <= err_d;
      end
   end

   // One line buffer feeds both ports; only the dv pulses pick the receiver.
   assign b_rdata_i = line_q;
   assign b_rdata_d = line_q;
   assign b_dv_i    = dvi_q;
   assign b_dv_d    = dvd_q;
   assign x_addr    = addr_q;
   assign x_rd      = x_rd_q;
   assign bus_err   = err_q;

endmodule

// File: tb/tb_mem_bus_arb.sv
// Bench for mem_bus_arb: directed cases with literal expectations plus a random run
// checked every cycle against a transaction-level model of the arbiter.
// Drives inputs 1 ns after the rising edge and compares outputs on the falling edge.
module tb_mem_bus_arb;

   localparam int BL = 58;
   localparam int LN = 512;
   localparam int TO = 8;

   logic          clk;
   logic          rst_n = 1'b1;
   logic [BL-1:0] b_addr_i, b_addr_d, x_addr;
   logic          b_rd_i, b_rd_d, b_dv_i, b_dv_d, x_rd, x_dv, bus_err;
   logic [LN-1:0] b_rdata_i, b_rdata_d, x_rdata;

   int n_vec = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // Transaction-level model: an outstanding read, a pending reply, who went last.
   bit            m_busy, m_resp, m_own, m_last;
   int            m_wait;
   logic [BL-1:0] m_addr;
   logic [LN-1:0] m_line;
   bit            e_dv_i, e_dv_d, e_err;
   int            gnt_q[$];

   mem_bus_arb #(.BLK_LEN(BL), .LINE(LN), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .b_addr_i  (b_addr_i),
      .b_rd_i    (b_rd_i),
      .b_rdata_i (b_rdata_i),
      .b_dv_i    (b_dv_i),
      .b_addr_d  (b_addr_d),
      .b_rd_d    (b_rd_d),
      .b_rdata_d (b_rdata_d),
      .b_dv_d    (b_dv_d),
      .x_addr    (x_addr),
      .x_rd      (x_rd),
      .x_rdata   (x_rdata),
      .x_dv      (x_dv),
      .bus_err   (bus_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic chka(input string nm, input logic [BL-1:0] act, input logic [BL-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic chkl(input string nm, input logic [LN-1:0] act, input logic [LN-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [LN-1:0] rand_line();
      logic [LN-1:0] r;
      for (int i = 0; i < LN / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [BL-1:0] rand_addr();
      logic [63:0] t;
      t = {$urandom, $urandom};
      return t[BL-1:0];
   endfunction

   task automatic model_reset();
      m_busy = 0; m_resp = 0; m_own = 0; m_last = 1; m_wait = 0;
      m_addr = '0; m_line = '0;
      e_dv_i = 0; e_dv_d = 0; e_err = 0;
   endtask

   // One clock edge of the arbiter's rules, seen as transactions.
   task automatic model_step();
      e_dv_i = 0; e_dv_d = 0; e_err = 0;
      if (m_resp) begin
         m_resp = 0;
         m_last = m_own;
      end else if (m_busy) begin
         m_wait++;
         if (x_dv) begin
            m_line = x_rdata;
            m_busy = 0;
            m_resp = 1;
            if (m_own) e_dv_d = b_rd_d;
            else       e_dv_i = b_rd_i;
         end else if (TO != 0 && m_wait == TO) begin
            m_busy = 0;
            e_err  = 1;
            m_last = m_own;
         end
      end else if (b_rd_i || b_rd_d) begin
         if (b_rd_i && b_rd_d) m_own = !m_last;
         else                  m_own = b_rd_d;
         m_addr = m_own ? b_addr_d : b_addr_i;
         m_busy = 1;
         m_wait = 0;
         gnt_q.push_back(int'(m_own));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_step();
      #1;
   endtask

   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      model_reset();
      b_rd_i = 0; b_rd_d = 0; x_dv = 0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk1("x_rd", x_rd, m_busy);
         chka("x_addr", x_addr, m_addr);
         chk1("b_dv_i", b_dv_i, e_dv_i);
         chk1("b_dv_d", b_dv_d, e_dv_d);
         chk1("bus_err", bus_err, e_err);
         chkl("b_rdata_i", b_rdata_i, m_line);
         chkl("b_rdata_d", b_rdata_d, m_line);
      end
   end

   initial begin
      logic [LN-1:0] pat_a;
      int            s0;
      int            pct;
      int            exp_g[4];

      b_addr_i = '0; b_addr_d = '0; b_rd_i = 0; b_rd_d = 0;
      x_dv = 0; x_rdata = '0;
      model_reset();
      do_reset();
      chk_en = 1'b1;

      // Reset state.
      chk1("rst x_rd", x_rd, 1'b0);
      chka("rst x_addr", x_addr, '0);
      chk1("rst bus_err", bus_err, 1'b0);
      chk1("rst b_dv_i", b_dv_i, 1'b0);
      chk1("rst b_dv_d", b_dv_d, 1'b0);
      chkl("rst line", b_rdata_i, '0);

      // Single dmem request, reply at cycle 5.
      pat_a    = rand_line();
      b_addr_d = 58'h1234;
      b_rd_d   = 1;
      tick();
      for (int c = 1; c <= 5; c++) begin
         chk1("t1 x_rd held", x_rd, 1'b1);
         chka("t1 x_addr", x_addr, 58'h1234);
         chk1("t1 b_dv_d early", b_dv_d, 1'b0);
         if (c == 5) begin x_dv = 1; x_rdata = pat_a; end
         tick();
      end
      x_dv = 0;
      chk1("t1 b_dv_d pulse", b_dv_d, 1'b1);
      chkl("t1 b_rdata_d", b_rdata_d, pat_a);
      chk1("t1 b_dv_i quiet", b_dv_i, 1'b0);
      chk1("t1 x_rd drop", x_rd, 1'b0);
      b_rd_d = 0;
      tick();
      chk1("t1 b_dv_d one cycle", b_dv_d, 1'b0);

      // Simultaneous requests after reset: imem first, then dmem.
      do_reset();
      b_addr_i = 58'hAAA; b_addr_d = 58'hBBB;
      b_rd_i = 1; b_rd_d = 1;
      tick();
      chka("t2 first addr", x_addr, 58'hAAA);
      x_dv = 1; x_rdata = rand_line();
      tick();
      x_dv = 0;
      chk1("t2 dv_i first", b_dv_i, 1'b1);
      chk1("t2 dv_d quiet", b_dv_d, 1'b0);
      b_rd_i = 0;
      tick(); tick();
      chka("t2 second addr", x_addr, 58'hBBB);
      chk1("t2 second x_rd", x_rd, 1'b1);
      x_dv = 1; x_rdata = rand_line();
      tick();
      x_dv = 0;
      chk1("t2 dv_d second", b_dv_d, 1'b1);
      chk1("t2 dv_i quiet", b_dv_i, 1'b0);
      b_rd_d = 0;
      tick(); tick();

      // Fairness: imem held high throughout, dmem re-requests after each reply.
      do_reset();
      b_addr_i = 58'h111; b_addr_d = 58'h222;
      b_rd_i = 1; b_rd_d = 1;
      s0 = gnt_q.size();
      for (int k = 0; k < 40 && gnt_q.size() < s0 + 4; k++) begin
         x_dv = x_rd; x_rdata = rand_line();
         tick();
         b_rd_d = !b_dv_d;
      end
      exp_g = '{0, 1, 0, 1};
      if (gnt_q.size() < s0 + 4) begin
         n_vec++; n_bad++;
         $display("FAIL t3 grant budget: got %0d grants want 4", gnt_q.size() - s0);
      end else begin
         for (int j = 0; j < 4; j++) begin
            n_vec++;
            if (gnt_q[s0 + j] != exp_g[j]) begin
               n_bad++;
               $display("FAIL t3 grant %0d: got %0d want %0d", j, gnt_q[s0 + j], exp_g[j]);
            end
         end
      end
      b_rd_i = 0; b_rd_d = 0;
      for (int k = 0; k < 6; k++) begin x_dv = x_rd; tick(); end
      x_dv = 0;

      // Abort: dmem lets go mid-read, pending imem goes next.
      do_reset();
      b_addr_d = 58'h2222; b_addr_i = 58'h3333;
      b_rd_d = 1;
      tick();
      b_rd_i = 1;
      tick(); tick();
      b_rd_d = 0;
      tick(); tick(); tick();
      x_dv = 1; x_rdata = rand_line();
      tick();
      x_dv = 0;
      chk1("t4 no dv_d", b_dv_d, 1'b0);
      chk1("t4 no dv_i", b_dv_i, 1'b0);
      chk1("t4 x_rd drop", x_rd, 1'b0);
      tick(); tick();
      chka("t4 next grant", x_addr, 58'h3333);
      chk1("t4 next x_rd", x_rd, 1'b1);
      x_dv = 1; x_rdata = rand_line();
      tick();
      x_dv = 0;
      chk1("t4 dv_i served", b_dv_i, 1'b1);
      b_rd_i = 0;
      tick(); tick();

      // Watchdog expiry with TIMEOUT=8, stray x_dv right after.
      do_reset();
      b_addr_i = 58'h4444;
      b_rd_i   = 1;
      tick();
      for (int e = 1; e <= 7; e++) begin
         tick();
         chk1("t5 no early err", bus_err, 1'b0);
         chk1("t5 x_rd held", x_rd, 1'b1);
      end
      tick();
      chk1("t5 bus_err", bus_err, 1'b1);
      chk1("t5 x_rd drop", x_rd, 1'b0);
      x_dv = 1; x_rdata = rand_line();
      tick();
      x_dv = 0;
      chk1("t5 err one cycle", bus_err, 1'b0);
      chk1("t5 no dv", b_dv_i, 1'b0);
      chk1("t5 reissue", x_rd, 1'b1);
      tick();
      chk1("t5 stray x_dv ignored", x_rd, 1'b1);
      chk1("t5 still no dv", b_dv_i, 1'b0);
      x_dv = 1; x_rdata = rand_line();
      tick();
      x_dv = 0;
      chk1("t5 dv after reissue", b_dv_i, 1'b1);
      b_rd_i = 0;
      tick(); tick();

      // Async reset mid-read; afterwards the first tie favours imem again.
      do_reset();
      b_addr_i = 58'h5555; b_addr_d = 58'h6666;
      b_rd_i = 1;
      tick();
      x_dv = 1; x_rdata = rand_line();
      tick();
      x_dv = 0; b_rd_i = 0;
      tick();
      b_rd_d = 1;
      tick(); tick();
      chk1("t6 busy before reset", x_rd, 1'b1);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk1("t6 async x_rd", x_rd, 1'b0);
      chk1("t6 async dv_i", b_dv_i, 1'b0);
      chk1("t6 async dv_d", b_dv_d, 1'b0);
      chk1("t6 async bus_err", bus_err, 1'b0);
      chka("t6 async x_addr", x_addr, '0);
      @(posedge clk);
      #3;
      rst_n  = 1'b1;
      b_rd_i = 1;
      tick();
      chka("t6 tie to imem", x_addr, 58'h5555);
      x_dv = 1; x_rdata = rand_line();
      tick();
      x_dv = 0; b_rd_i = 0;
      for (int k = 0; k < 6; k++) begin x_dv = x_rd; tick(); end
      x_dv = 0;

      // Random traffic; bus reply rate changes in phases, including silent phases.
      do_reset();
      pct = 30;
      for (int c = 0; c < 3000; c++) begin
         if (c % 64 == 0) pct = ($urandom % 4 == 0) ? 0 : int'($urandom_range(10, 70));
         x_dv    = int'($urandom % 100) < pct;
         x_rdata = rand_line();
         tick();
         if (b_dv_i) b_rd_i = 0;
         else if (b_rd_i) begin
            if ($urandom % 100 < 2) b_rd_i = 0;
         end else if ($urandom % 100 < 40) begin
            b_rd_i = 1; b_addr_i = rand_addr();
         end
         if (b_dv_d) b_rd_d = 0;
         else if (b_rd_d) begin
            if ($urandom % 100 < 2) b_rd_d = 0;
         end else if ($urandom % 100 < 40) begin
            b_rd_d = 1; b_addr_d = rand_addr();
         end
         if ($urandom % 100 < 5) b_addr_i = rand_addr();
         if ($urandom % 100 < 5) b_addr_d = rand_addr();
      end

      @(negedge clk);
      #1;
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
